// File: rtl/clock_pkg.sv
// Shared types and constants for the clock_set_controller slice.
package clock_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } mode_t;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
endpackage

// File: rtl/button_conditioner.sv
// Raw push button -> 2-flop synchronizer -> optional debouncer -> rising-edge
// detector, giving a one-cycle press pulse.
// Build option: CLOCK_SET_DEBOUNCE_EN inserts the debouncer.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_btn,
  output logic o_press
);

  logic [1:0] r_sync;
  logic       w_sync;
  logic       w_level;
  logic       r_prev;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (!resetN) r_sync <= '0;
    else         r_sync <= {r_sync[0], i_btn};
  end

  assign w_sync = r_sync[1];

`ifdef CLOCK_SET_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // Filtered level follows the synchronized level only after it has disagreed
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_filt <= w_sync;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  // Debounce length is meaningless without the filter.
  logic w_unused_dbc;
  assign w_unused_dbc = (DEBOUNCE_CYCLES < 1);
  assign w_level      = w_sync;
`endif

  // Previous level for rising-edge detection; cleared in reset so a button
  // held through reset release still yields one press.
  always_ff @(posedge clk) begin
    if (!resetN) r_prev <= 1'b0;
    else         r_prev <= w_level;
  end

  assign o_press = w_level & ~r_prev;

endmodule

// File: rtl/clock_set_controller.sv
// Timekeeping and time-set sequencer: 1 Hz prescaler, seconds/minutes
// counters, hour_inc strobes and a RUN/SET_MIN/SET_HOUR mode machine.
// Build option: CLOCK_SET_DEBOUNCE_EN enables button debouncing.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             mode_btn,
  input  logic             inc_btn,
  output logic [SEC_W-1:0] OutSec,
  output logic [MIN_W-1:0] OutMin,
  output logic             hour_inc,
  output logic [1:0]       mode,
  output logic             set_blink
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int BW = $clog2(CLK_HZ / 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(CLK_HZ / 2 - 1);

  mode_t            r_state, w_next;
  logic             w_mode_press, w_inc_press, w_inc, w_tick;
  logic [PW-1:0]    r_presc;
  logic [BW-1:0]    r_bcnt;
  logic [SEC_W-1:0] r_sec;
  logic [MIN_W-1:0] r_min;
  logic             r_hour_inc, r_blink;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk(clk), .resetN(resetN), .i_btn(mode_btn), .o_press(w_mode_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_btn (
    .clk(clk), .resetN(resetN), .i_btn(inc_btn), .o_press(w_inc_press)
  );

  // Mode press always wins over a simultaneous inc press.
  assign w_inc  = w_inc_press & ~w_mode_press;
  // A tick that coincides with leaving RUN is dropped together with its carries.
  assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST) && !w_mode_press;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (!resetN) r_state <= RUN;
    else         r_state <= w_next;
  end

  // Next state: each mode press advances RUN -> SET_MIN -> SET_HOUR -> RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:      if (w_mode_press) w_next = SET_MIN;
      SET_MIN:  if (w_mode_press) w_next = SET_HOUR;
      SET_HOUR: if (w_mode_press) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  // Prescaler runs only in RUN and restarts from 0 on every mode change.
  always_ff @(posedge clk) begin
    if (!resetN)
      r_presc <= '0;
    else if (r_state != RUN || w_mode_press || r_presc == PRESC_LAST)
      r_presc <= '0;
    else
      r_presc <= r_presc + 1'b1;
  end

  // Seconds/minutes counters and hour strobe.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hour_inc <= 1'b0;
    end else begin
      r_hour_inc <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_mode_press) begin
            r_sec <= '0;
          end else if (w_tick) begin
            if (r_sec == SEC_MAX) begin
              r_sec <= '0;
              if (r_min == MIN_MAX) begin
                r_min      <= '0;
                r_hour_inc <= 1'b1;
              end else begin
                r_min <= r_min + 1'b1;
              end
            end else begin
              r_sec <= r_sec + 1'b1;
            end
          end
        end
        SET_MIN:  if (w_inc) r_min <= (r_min == MIN_MAX) ? '0 : r_min + 1'b1;
        SET_HOUR: if (w_inc) r_hour_inc <= 1'b1;
        default: ;
      endcase
    end
  end

  // Blink: held low in RUN and on the edge returning to RUN; free-running
  // half-period toggle across both SET states.
  always_ff @(posedge clk) begin
    if (!resetN || r_state == RUN || w_next == RUN) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_bcnt == BLINK_LAST) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  assign OutSec    = r_sec;
  assign OutMin    = r_min;
  assign hour_inc  = r_hour_inc;
  assign mode      = r_state;
  assign set_blink = r_blink;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller (CLK_HZ=10, DEBOUNCE_CYCLES=4).
// Honours CLOCK_SET_DEBOUNCE_EN for button latency and the debounce scenario.
module tb_clock_set_controller;

  localparam int CLK_HZ = 10;
  localparam int DBC    = 4;
`ifdef CLOCK_SET_DEBOUNCE_EN
  localparam int LAT  = DBC + 3;
  localparam int HOLD = DBC + 2;
  localparam int GAP  = DBC + 3;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 1;
  localparam int GAP  = 2;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [5:0] OutSec, OutMin;
  logic       hour_inc, set_blink;
  logic [1:0] mode;

  clock_set_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DBC)) dut (
    .clk(clk), .resetN(resetN), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .OutSec(OutSec), .OutMin(OutMin), .hour_inc(hour_inc),
    .mode(mode), .set_blink(set_blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: wall time kept as total seconds within the hour, button
  // effects scheduled at (first sampling edge + latency).
  int m_mode = 0, m_sec = 0, m_min = 0, m_phase = 0, m_set = 0;
  bit m_hour = 1'b0;
  int edge_n = 0;
  int mode_q[$];
  int inc_q[$];
  int hour_cnt = 0;
  bit prev_hour = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit mp, ip;
    int t;
    mp = (mode_q.size() > 0) && (mode_q[0] == edge_n);
    ip = (inc_q.size() > 0) && (inc_q[0] == edge_n);
    if (mp) mode_q.delete(0);
    if (ip) inc_q.delete(0);
    m_hour = 1'b0;
    if (!resetN) begin
      m_mode = 0; m_sec = 0; m_min = 0; m_phase = 0; m_set = 0;
      mode_q.delete(); inc_q.delete();
    end else begin
      case (m_mode)
        0: if (mp) begin
             m_mode = 1; m_sec = 0; m_phase = 0; m_set = 0;
           end else if (m_phase == CLK_HZ - 1) begin
             m_phase = 0;
             t = m_min * 60 + m_sec + 1;
             if (t == 3600) begin t = 0; m_hour = 1'b1; end
             m_min = t / 60;
             m_sec = t % 60;
           end else m_phase++;
        1: begin
             m_set++;
             if (mp) m_mode = 2;
             else if (ip) m_min = (m_min + 1) % 60;
           end
        default: begin
             m_set++;
             if (mp) begin m_mode = 0; m_phase = 0; end
             else if (ip) m_hour = 1'b1;
           end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    chk("OutSec", OutSec, m_sec);
    chk("OutMin", OutMin, m_min);
    chk("mode", mode, m_mode);
    chk("hour_inc", hour_inc, m_hour);
    chk("set_blink", set_blink, (m_mode == 0) ? 0 : (m_set / (CLK_HZ / 2)) % 2);
    if (hour_inc === 1'b1) begin
      hour_cnt++;
      chk("hour_inc_back_to_back", prev_hour, 0);
    end
    prev_hour = hour_inc;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input bit m, input bit i);
    if (m) mode_q.push_back(edge_n + LAT);
    if (i) inc_q.push_back(edge_n + LAT);
    mode_btn = m;
    inc_btn  = i;
    repeat (HOLD) step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (GAP) step();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
  endtask

  task automatic set_min_to(input int target);
    int n;
    n = (target - m_min + 60) % 60;
    repeat (n) press(1'b0, 1'b1);
  endtask

  task automatic goto_mode(input int target);
    for (int k = 0; k < 3 && m_mode != target; k++) press(1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_min, found, seen;

    // Reset state
    resetN = 1'b0;
    run(2);
    chk("rst_mode", mode, 0);
    chk("rst_sec", OutSec, 0);
    chk("rst_blink", set_blink, 0);
    resetN = 1'b1;

    // 1: 600 cycles of RUN = one minute
    hour_cnt = 0;
    run(600);
    chk("t1_min", OutMin, 1);
    chk("t1_sec", OutSec, 0);
    chk("t1_hour_cnt", hour_cnt, 0);

    // 2: minutes to 59, then roll over the hour
    do_reset();
    press(1'b1, 1'b0);
    chk("t2_mode_set_min", mode, 1);
    repeat (59) press(1'b0, 1'b1);
    chk("t2_min59", OutMin, 59);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t2_mode_run", mode, 0);
    hour_cnt = 0;
    run(600);
    chk("t2_hour_cnt", hour_cnt, 1);
    chk("t2_min", OutMin, 0);
    chk("t2_sec", OutSec, 0);

    // Random mix of run lengths and presses
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(1, 120));
      case ($urandom_range(0, 2))
        0: press(1'b1, 1'b0);
        1: press(1'b0, 1'b1);
        default: press(1'b1, 1'b1);
      endcase
    end
    goto_mode(0);

    // 3: hour strobes in SET_HOUR, minute wrap in SET_MIN
    goto_mode(2);
    chk("t3_mode_set_hour", mode, 2);
    exp_min = m_min;
    hour_cnt = 0;
    repeat (3) press(1'b0, 1'b1);
    chk("t3_hour_cnt", hour_cnt, 3);
    chk("t3_min_kept", OutMin, exp_min);
    chk("t3_sec_zero", OutSec, 0);
    goto_mode(1);
    set_min_to(59);
    hour_cnt = 0;
    press(1'b0, 1'b1);
    chk("t3_min_wrap", OutMin, 0);
    chk("t3_wrap_no_hour", hour_cnt, 0);

    // 4a: mode and inc in the same cycle from RUN
    goto_mode(0);
    run($urandom_range(1, 250));
    press(1'b1, 1'b1);
    chk("t4_mode", mode, 1);
    chk("t4_min", OutMin, 0);

    // 4b: mode press landing on the 59:59 tick edge
    set_min_to(59);
    goto_mode(0);
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      if (m_sec == 59 && m_phase == CLK_HZ - LAT) found = 1;
      else step();
    end
    chk("t4_align_found", found, 1);
    hour_cnt = 0;
    press(1'b1, 1'b0);
    chk("t4_tick_mode", mode, 1);
    chk("t4_tick_sec", OutSec, 0);
    chk("t4_tick_min", OutMin, 59);
    chk("t4_tick_no_hour", hour_cnt, 0);

`ifdef CLOCK_SET_DEBOUNCE_EN
    // 5: glitch rejected, 6-cycle hold advances exactly once after 7 edges
    mode_btn = 1'b1;
    run(3);
    mode_btn = 1'b0;
    run(12);
    chk("t5_glitch_mode", mode, 1);
    mode_q.push_back(edge_n + LAT);
    mode_btn = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 7) mode_btn = 1'b0;
      step();
      if (seen == 0 && mode !== 2'd1) seen = k;
    end
    chk("t5_latency", seen, 7);
    chk("t5_single_advance", mode, 2);
`endif

    // 6: reset while in SET_HOUR with minutes = 17
    goto_mode(1);
    set_min_to(17);
    goto_mode(2);
    run($urandom_range(1, 20));
    chk("t6_pre_mode", mode, 2);
    chk("t6_pre_min", OutMin, 17);
    do_reset();
    chk("t6_mode", mode, 0);
    chk("t6_min", OutMin, 0);
    chk("t6_sec", OutSec, 0);
    chk("t6_blink", set_blink, 0);
    chk("t6_hour_inc", hour_inc, 0);
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
